// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the execute stage and the multiply/divide sequencer.
// Latency: none, wires only; the sequencer owns all timing.
// Backpressure: md_o_busy stalls EX; EX holds md_i_ce upstream until busy drops.
interface muldiv_sequencer_if #(
    parameter int DWIDTH = 32
);
    logic              md_i_ce;
    logic [1:0]        md_i_op;
    logic [DWIDTH-1:0] md_i_rs;
    logic [DWIDTH-1:0] md_i_rt;
    logic              md_i_flush;
    logic              md_i_mthi;
    logic              md_i_mtlo;
    logic              md_o_busy;
    logic              md_o_done;
    logic [DWIDTH-1:0] md_o_hi;
    logic [DWIDTH-1:0] md_o_lo;

    // Execute-stage side: issues ops, reads HI/LO and the stall request
    modport master (
        output md_i_ce, md_i_op, md_i_rs, md_i_rt, md_i_flush, md_i_mthi, md_i_mtlo,
        input  md_o_busy, md_o_done, md_o_hi, md_o_lo
    );

    // Sequencer side
    modport slave (
        input  md_i_ce, md_i_op, md_i_rs, md_i_rt, md_i_flush, md_i_mthi, md_i_mtlo,
        output md_o_busy, md_o_done, md_o_hi, md_o_lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer (shift-add multiply, restoring divide) owning HI/LO.
// Latency: issue at t, done pulse and HI/LO update visible at t+DWIDTH+2 (t+2 for divide by zero).
// Backpressure: busy stalls EX while an op is in flight; md_i_ce outside IDLE is ignored.
// Optional MD_MTHILO_EN: direct HI/LO writes (mthi/mtlo) from md_i_rs while idle.
module muldiv_sequencer #(
    parameter int DWIDTH = 32,
    parameter int CNT_W  = 6
) (
    input  logic               md_i_clk,
    input  logic               md_i_rst_n,
    muldiv_sequencer_if.slave  md
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int W = DWIDTH;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0]   prod;       // mult: {acc, multiplier}; div: {remainder, dividend/quotient}
    logic [W-1:0]     opnd_b;     // multiplicand or divisor magnitude
    logic             is_div;
    logic             neg_lo;     // negate product / quotient at FIX
    logic             neg_hi;     // negate remainder at FIX
    logic             div_zero;   // prod already holds the raw {rs, all-ones} result
    logic [W-1:0]     hi_q;
    logic [W-1:0]     lo_q;

    logic             issue;
    logic             signed_op;
    logic             sign_a;
    logic             sign_b;
    logic [W-1:0]     abs_a;
    logic [W-1:0]     abs_b;

    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;
    logic             div_ge;
    logic [W-1:0]     div_rem;
    logic [2*W-1:0]   step_prod;
    logic [2*W-1:0]   prod_neg;
    logic [W-1:0]     fix_hi;
    logic [W-1:0]     fix_lo;

    // A flush in IDLE squashes the instruction trying to issue this cycle
    assign issue     = (state == S_IDLE) && md.md_i_ce && !md.md_i_flush;
    assign signed_op = ~md.md_i_op[0];
    assign sign_a    = signed_op & md.md_i_rs[W-1];
    assign sign_b    = signed_op & md.md_i_rt[W-1];
    assign abs_a     = sign_a ? -md.md_i_rs : md.md_i_rs;
    assign abs_b     = sign_b ? -md.md_i_rt : md.md_i_rt;

    // One iteration of the shared datapath: shift-add for mult, restoring step for div
    always_comb begin
        mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, opnd_b} : '0);
        div_shift = {prod[2*W-1:W], prod[W-1]};
        div_ge    = div_shift >= {1'b0, opnd_b};
        div_rem   = div_ge ? W'(div_shift - {1'b0, opnd_b}) : div_shift[W-1:0];
        step_prod = is_div ? {div_rem, prod[W-2:0], div_ge} : {mul_sum, prod[W-1:1]};
    end

    // Sign fix-up of the magnitude result into the HI/LO values committed at FIX
    always_comb begin
        prod_neg = -prod;
        fix_hi   = prod[2*W-1:W];
        fix_lo   = prod[W-1:0];
        if (!div_zero) begin
            if (is_div) begin
                fix_lo = neg_lo ? -prod[W-1:0]   : prod[W-1:0];
                fix_hi = neg_hi ? -prod[2*W-1:W] : prod[2*W-1:W];
            end else if (neg_lo) begin
                fix_hi = prod_neg[2*W-1:W];
                fix_lo = prod_neg[W-1:0];
            end
        end
    end

    // Control FSM and working registers
    always_ff @(posedge md_i_clk or negedge md_i_rst_n) begin
        if (!md_i_rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            prod     <= '0;
            opnd_b   <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        cnt    <= CNT_W'(W);
                        opnd_b <= abs_b;
                        is_div <= md.md_i_op[1];
                        neg_lo <= sign_a ^ sign_b;
                        neg_hi <= sign_a;
                        // Divide by zero skips the iterations but still commits through FIX
                        if (md.md_i_op[1] && (md.md_i_rt == '0)) begin
                            prod     <= {md.md_i_rs, {W{1'b1}}};
                            div_zero <= 1'b1;
                            state    <= S_FIX;
                        end else begin
                            prod     <= {{W{1'b0}}, abs_a};
                            div_zero <= 1'b0;
                            state    <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (md.md_i_flush) begin
                        state <= S_IDLE;
                    end else begin
                        prod <= step_prod;
                        cnt  <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) state <= S_FIX;
                    end
                end
                S_FIX:   state <= md.md_i_flush ? S_IDLE : S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // HI/LO: committed at FIX unless flushed; optionally written directly while idle
    always_ff @(posedge md_i_clk or negedge md_i_rst_n) begin
        if (!md_i_rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == S_FIX && !md.md_i_flush) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end
`ifdef MD_MTHILO_EN
        else if (state == S_IDLE && !md.md_i_ce) begin
            if (md.md_i_mthi) hi_q <= md.md_i_rs;
            if (md.md_i_mtlo) lo_q <= md.md_i_rs;
        end
`endif
    end

`ifndef MD_MTHILO_EN
    logic unused_mthilo;
    assign unused_mthilo = md.md_i_mthi ^ md.md_i_mtlo;
`endif

    // busy drops in the DONE cycle so EX can issue the next op right after the pulse
    assign md.md_o_busy = (state == S_CALC) || (state == S_FIX) || ((state == S_IDLE) && md.md_i_ce);
    assign md.md_o_done = (state == S_DONE);
    assign md.md_o_hi   = hi_q;
    assign md.md_o_lo   = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized scoreboard bench for muldiv_sequencer against a plain-arithmetic reference.
// Latency: expects done at issue+DWIDTH+2 (issue+2 for divide by zero).
// Backpressure: issues only when the sequencer is idle, as the hazard unit would.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.DWIDTH(W)) md_if ();

    muldiv_sequencer #(.DWIDTH(W), .CNT_W(6)) dut (
        .md_i_clk  (clk),
        .md_i_rst_n(rst_n),
        .md        (md_if)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        scoreboard[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: full-width arithmetic, then take the architectural HI/LO halves
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sbv;
        logic [63:0] r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            2'd0:    r = 64'(sa * sbv);
            2'd1:    r = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 32'd0)     r = {a, 32'hFFFF_FFFF};
                else if (op == 2'd2) r = {32'(sa % sbv), 32'(sa / sbv)};
                else                 r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && md_if.md_o_done === 1'b1) begin
            if (scoreboard.size() == 0) begin
                check("spurious_done", 64'(md_if.md_o_done), 64'd0);
            end else begin
                mon_e = scoreboard.pop_front();
                check("hi", 64'(md_if.md_o_hi), 64'(mon_e.hi));
                check("lo", 64'(md_if.md_o_lo), 64'(mon_e.lo));
                check("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
            end
        end
    end

    task automatic set_idle();
        md_if.md_i_ce    = 1'b0;
        md_if.md_i_flush = 1'b0;
        md_if.md_i_mthi  = 1'b0;
        md_if.md_i_mtlo  = 1'b0;
    endtask

    // Issue one op, track busy over its lifetime, confirm the scoreboard drained
    task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input bit mtlo_mid);
        logic [63:0] r;
        int          lat;
        bit          busy_ok;
        r       = ref_result(op, rs, rt);
        lat     = (op[1] && rt == 32'd0) ? 2 : W + 2;
        busy_ok = 1'b1;
        @(negedge clk);
        md_if.md_i_ce = 1'b1;
        md_if.md_i_op = op;
        md_if.md_i_rs = rs;
        md_if.md_i_rt = rt;
        scoreboard.push_back('{r[63:32], r[31:0], lat, cyc});
        #1 if (md_if.md_o_busy !== 1'b1) busy_ok = 1'b0;
        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            if (n == 1) begin
                md_if.md_i_ce = 1'b0;
                md_if.md_i_rs = $urandom;
                md_if.md_i_rt = $urandom;
            end
            if (mtlo_mid && n == 5) md_if.md_i_mtlo = 1'b1;
            if (mtlo_mid && n == 6) begin
                md_if.md_i_mtlo = 1'b0;
                check("mtlo_in_calc", 64'(md_if.md_o_lo), 64'(model_lo));
            end
            #1 if (md_if.md_o_busy !== (n < lat)) busy_ok = 1'b0;
        end
        check("busy_window", 64'(busy_ok), 64'd1);
        @(negedge clk);
        #1 check("done_seen", 64'(scoreboard.size()), 64'd0);
        scoreboard.delete();
        model_hi = r[63:32];
        model_lo = r[31:0];
    endtask

    initial begin
        set_idle();
        md_if.md_i_op = 2'd0;
        md_if.md_i_rs = '0;
        md_if.md_i_rt = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_hi", 64'(md_if.md_o_hi), 64'd0);
        check("rst_lo", 64'(md_if.md_o_lo), 64'd0);
        check("rst_busy", 64'(md_if.md_o_busy), 64'd0);
        check("rst_done", 64'(md_if.md_o_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
        run_op(2'd3, 32'd100, 32'd7, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'd2, 32'h0000_002A, 32'd0, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);

        // Flush mid-CALC: abort, HI/LO untouched, next issue accepted
        @(negedge clk);
        md_if.md_i_ce = 1'b1;
        md_if.md_i_op = 2'd0;
        md_if.md_i_rs = $urandom;
        md_if.md_i_rt = $urandom;
        @(negedge clk);
        md_if.md_i_ce = 1'b0;
        repeat (9) @(negedge clk);
        md_if.md_i_flush = 1'b1;
        @(negedge clk);
        md_if.md_i_flush = 1'b0;
        #1;
        check("flush_busy", 64'(md_if.md_o_busy), 64'd0);
        check("flush_hi", 64'(md_if.md_o_hi), 64'(model_hi));
        check("flush_lo", 64'(md_if.md_o_lo), 64'(model_lo));
        run_op(2'd1, 32'h1234_5678, 32'h0000_0010, 1'b0);

        // Direct HI write while idle
        @(negedge clk);
        md_if.md_i_mthi = 1'b1;
        md_if.md_i_rs   = 32'h1234_5678;
        @(negedge clk);
        md_if.md_i_mthi = 1'b0;
`ifdef MD_MTHILO_EN
        model_hi = 32'h1234_5678;
`endif
        #1;
        check("mthi_hi", 64'(md_if.md_o_hi), 64'(model_hi));
        check("mthi_busy", 64'(md_if.md_o_busy), 64'd0);

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            run_op(op, pick(), pick(), 1'($urandom_range(0, 1)));
        end

        // Async reset mid-DIVU: outputs clear without a clock edge
        @(negedge clk);
        md_if.md_i_ce = 1'b1;
        md_if.md_i_op = 2'd3;
        md_if.md_i_rs = 32'hDEAD_BEEF;
        md_if.md_i_rt = 32'd3;
        @(negedge clk);
        md_if.md_i_ce = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(md_if.md_o_busy), 64'd0);
        check("arst_done", 64'(md_if.md_o_done), 64'd0);
        check("arst_hi", 64'(md_if.md_o_hi), 64'd0);
        check("arst_lo", 64'(md_if.md_o_lo), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        model_hi = '0;
        model_lo = '0;
        run_op(2'd2, 32'hFFFF_FF00, 32'd16, 1'b0);
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete (checks %0d)", checks);
        $fatal(1, "timeout");
    end
endmodule
